// File: rtl/mst_stream_src.sv
// Framed streaming source for the Master FIFO read path (FPGA to host).
// Four independent per-channel packet generators feed the pre-fetch stage via a
// show-ahead req/dat/vld interface. Each packet is a header word, pkt_len payload
// words of a per-channel incrementing counter and, with MST_SRC_CRC_EN defined,
// an XOR checksum trailer.
// Optional feature macro: MST_SRC_CRC_EN (default build: undefined, no trailer).
module mst_stream_src #(
   parameter int unsigned SEQ_W   = 16,
   parameter int unsigned MAX_LEN = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mltcn,
   input  logic [3:0]  ch_en,
   input  logic [15:0] pkt_len,
   input  logic        ch0_req,
   input  logic        ch1_req,
   input  logic        ch2_req,
   input  logic        ch3_req,
   output logic [31:0] ch0_dat,
   output logic [31:0] ch1_dat,
   output logic [31:0] ch2_dat,
   output logic [31:0] ch3_dat,
   output logic [3:0]  ch_vld,
   output logic [3:0]  ch_eop,
   output logic [3:0]  pkt_done,
   output logic [3:0]  req_err
);

   typedef enum logic [1:0] {
      StIdle,
      StHdr,
`ifdef MST_SRC_CRC_EN
      StPay,
      StTrl
`else
      StPay
`endif
   } st_e;

   localparam logic [15:0] MaxLen16 = 16'(MAX_LEN);

   logic [15:0] len_clamp;
   logic [3:0]  req_v;
   logic [31:0] dat_arr [4];

   assign len_clamp = (pkt_len > MaxLen16) ? MaxLen16 : pkt_len;
   assign req_v     = {ch3_req, ch2_req, ch1_req, ch0_req};

   for (genvar n = 0; n < 4; n++) begin : g_ch
      localparam logic [1:0] ChId  = 2'(n);
      localparam bit         IsCh0 = (n == 0);

      st_e              state_q, state_d;
      logic [15:0]      rem_q, rem_d;
      logic [SEQ_W-1:0] seq_q, seq_d;
      logic [31:0]      pay_q, pay_d;
      logic [31:0]      dat_q, dat_d;
      logic             vld_q, vld_d;
      logic             eop_q, eop_d;
      logic             done_q, done_d;
      logic             err_q, err_d;
`ifdef MST_SRC_CRC_EN
      logic [31:0]      crc_q, crc_d;
`endif
      logic             active, pop, fin;

      assign active = ch_en[n] & (IsCh0 | mltcn);
      assign pop    = req_v[n] & vld_q;

      // Next-state and next-word computation; outputs are registered so dat_d is
      // the word that will be visible in the following cycle.
      always_comb begin
         state_d = state_q;
         rem_d   = rem_q;
         seq_d   = seq_q;
         pay_d   = pay_q;
         dat_d   = dat_q;
         vld_d   = vld_q;
         eop_d   = eop_q;
         done_d  = 1'b0;
         err_d   = err_q | (req_v[n] & ~vld_q);
         fin     = 1'b0;
`ifdef MST_SRC_CRC_EN
         crc_d   = crc_q;
`endif
         unique case (state_q)
            StIdle: begin
               // The pkt_done cycle is a mandatory gap before the next header
               if (active && !done_q) begin
                  state_d = StHdr;
                  rem_d   = len_clamp;
                  vld_d   = 1'b1;
                  dat_d   = {8'hA5, 6'b0, ChId, 16'(seq_q)};
`ifdef MST_SRC_CRC_EN
                  eop_d   = 1'b0;
                  crc_d   = '0;
`else
                  eop_d   = (len_clamp == 16'd0);
`endif
               end
            end
            StHdr: begin
               if (pop) begin
                  if (rem_q != 16'd0) begin
                     state_d = StPay;
                     dat_d   = pay_q;
`ifdef MST_SRC_CRC_EN
                     eop_d   = 1'b0;
`else
                     eop_d   = (rem_q == 16'd1);
`endif
                  end else begin
`ifdef MST_SRC_CRC_EN
                     state_d = StTrl;
                     dat_d   = crc_q;
                     eop_d   = 1'b1;
`else
                     fin     = 1'b1;
`endif
                  end
               end
            end
            StPay: begin
               if (pop) begin
                  pay_d = pay_q + 32'd1;
                  rem_d = rem_q - 16'd1;
`ifdef MST_SRC_CRC_EN
                  crc_d = crc_q ^ pay_q;
`endif
                  if (rem_q == 16'd1) begin
`ifdef MST_SRC_CRC_EN
                     state_d = StTrl;
                     dat_d   = crc_q ^ pay_q;
                     eop_d   = 1'b1;
`else
                     fin     = 1'b1;
`endif
                  end else begin
                     dat_d = pay_q + 32'd1;
`ifndef MST_SRC_CRC_EN
                     eop_d = (rem_q == 16'd2);
`endif
                  end
               end
            end
`ifdef MST_SRC_CRC_EN
            StTrl: begin
               if (pop) fin = 1'b1;
            end
`endif
            default: state_d = StIdle;
         endcase
         if (fin) begin
            state_d = StIdle;
            vld_d   = 1'b0;
            eop_d   = 1'b0;
            dat_d   = '0;
            done_d  = 1'b1;
            seq_d   = seq_q + SEQ_W'(1);
         end
      end

      // Channel state and registered outputs; rst abandons any packet in flight
      always_ff @(posedge clk) begin
         if (rst) begin
            state_q <= StIdle;
            rem_q   <= '0;
            seq_q   <= '0;
            pay_q   <= '0;
            dat_q   <= '0;
            vld_q   <= 1'b0;
            eop_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef MST_SRC_CRC_EN
            crc_q   <= '0;
`endif
         end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            seq_q   <= seq_d;
            pay_q   <= pay_d;
            dat_q   <= dat_d;
            vld_q   <= vld_d;
            eop_q   <= eop_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef MST_SRC_CRC_EN
            crc_q   <= crc_d;
`endif
         end
      end

      assign dat_arr[n]  = dat_q;
      assign ch_vld[n]   = vld_q;
      assign ch_eop[n]   = eop_q;
      assign pkt_done[n] = done_q;
      assign req_err[n]  = err_q;
   end

   assign ch0_dat = dat_arr[0];
   assign ch1_dat = dat_arr[1];
   assign ch2_dat = dat_arr[2];
   assign ch3_dat = dat_arr[3];

endmodule

// File: tb/tb_mst_stream_src.sv
// Directed bench for mst_stream_src; expectations follow MST_SRC_CRC_EN.
module tb_mst_stream_src;

   logic        clk = 1'b0;
   logic        rst;
   logic        mltcn;
   logic [3:0]  ch_en;
   logic [15:0] pkt_len;
   logic [3:0]  req;
   logic [31:0] ch0_dat, ch1_dat, ch2_dat, ch3_dat;
   logic [3:0]  ch_vld, ch_eop, pkt_done, req_err;

   int n_cmp  = 0;
   int n_fail = 0;

   // Expected word per cycle: {vld, eop, done, dat}
   logic [34:0] exp_q [$];

   mst_stream_src #(.SEQ_W(16), .MAX_LEN(4096)) dut (
      .clk      (clk),
      .rst      (rst),
      .mltcn    (mltcn),
      .ch_en    (ch_en),
      .pkt_len  (pkt_len),
      .ch0_req  (req[0]),
      .ch1_req  (req[1]),
      .ch2_req  (req[2]),
      .ch3_req  (req[3]),
      .ch0_dat  (ch0_dat),
      .ch1_dat  (ch1_dat),
      .ch2_dat  (ch2_dat),
      .ch3_dat  (ch3_dat),
      .ch_vld   (ch_vld),
      .ch_eop   (ch_eop),
      .pkt_done (pkt_done),
      .req_err  (req_err)
   );

   always #5 clk = ~clk;

   function automatic logic [34:0] wd(input logic [31:0] d, input logic e);
      return {1'b1, e, 1'b0, d};
   endfunction

   function automatic logic [34:0] gap(input logic d);
      return {1'b0, 1'b0, d, 32'h0};
   endfunction

   // Leaves rst asserted at a falling edge; caller configures and releases
   task automatic do_reset();
      rst = 1'b1;
      req = 4'h0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      mltcn = 1'b1; ch_en = 4'hF; pkt_len = 16'd3;
      do_reset();
      req = 4'hF;
      @(negedge clk);
      n_cmp++;
      if ({ch_vld, ch_eop, pkt_done, req_err} !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_flags: vld=%b eop=%b done=%b err=%b, want all 0",
                  ch_vld, ch_eop, pkt_done, req_err);
      end
      n_cmp++;
      if ({ch0_dat, ch1_dat, ch2_dat, ch3_dat} !== 128'h0) begin
         n_fail++;
         $display("FAIL reset_dat: %h %h %h %h, want all 0", ch0_dat, ch1_dat, ch2_dat, ch3_dat);
      end
   endtask

   // 245 mode, len 3, req held high: two packets on channel 0 only
   task automatic test_basic();
      do_reset();
      mltcn = 1'b0; ch_en = 4'hF; pkt_len = 16'd3; req = 4'b0001; rst = 1'b0;
      exp_q.delete();
`ifdef MST_SRC_CRC_EN
      exp_q.push_back(wd(32'hA500_0000, 0)); exp_q.push_back(wd(32'd0, 0));
      exp_q.push_back(wd(32'd1, 0));         exp_q.push_back(wd(32'd2, 0));
      exp_q.push_back(wd(32'd3, 1));
      exp_q.push_back(gap(1));               exp_q.push_back(gap(0));
      exp_q.push_back(wd(32'hA500_0001, 0)); exp_q.push_back(wd(32'd3, 0));
      exp_q.push_back(wd(32'd4, 0));         exp_q.push_back(wd(32'd5, 0));
      exp_q.push_back(wd(32'd2, 1));
      exp_q.push_back(gap(1));
`else
      exp_q.push_back(wd(32'hA500_0000, 0)); exp_q.push_back(wd(32'd0, 0));
      exp_q.push_back(wd(32'd1, 0));         exp_q.push_back(wd(32'd2, 1));
      exp_q.push_back(gap(1));               exp_q.push_back(gap(0));
      exp_q.push_back(wd(32'hA500_0001, 0)); exp_q.push_back(wd(32'd3, 0));
      exp_q.push_back(wd(32'd4, 0));         exp_q.push_back(wd(32'd5, 1));
      exp_q.push_back(gap(1));
`endif
      for (int i = 0; i < exp_q.size(); i++) begin
         @(negedge clk);
         n_cmp++;
         if (ch_vld[0] !== exp_q[i][34] || ch_eop[0] !== exp_q[i][33] ||
             pkt_done[0] !== exp_q[i][32] || (exp_q[i][34] && ch0_dat !== exp_q[i][31:0]) ||
             ch_vld[3:1] !== 3'b000 || pkt_done[3:1] !== 3'b000) begin
            n_fail++;
            $display("FAIL basic[%0d]: vld=%b eop=%b done=%b dat=%h, want vld=%b eop=%b done=%b dat=%h",
                     i, ch_vld, ch_eop[0], pkt_done, ch0_dat, exp_q[i][34], exp_q[i][33],
                     exp_q[i][32], exp_q[i][31:0]);
         end
      end
      pkt_len = 16'd2;
   endtask

   // Continues from test_basic: payload 6,7 then trailer 6^7 when enabled
   task automatic test_trailer();
      exp_q.delete();
      exp_q.push_back(gap(0));
      exp_q.push_back(wd(32'hA500_0002, 0));
      exp_q.push_back(wd(32'd6, 0));
`ifdef MST_SRC_CRC_EN
      exp_q.push_back(wd(32'd7, 0));
      exp_q.push_back(wd(32'h0000_0001, 1));
`else
      exp_q.push_back(wd(32'd7, 1));
`endif
      exp_q.push_back(gap(1));
      for (int i = 0; i < exp_q.size(); i++) begin
         @(negedge clk);
         n_cmp++;
         if (ch_vld[0] !== exp_q[i][34] || ch_eop[0] !== exp_q[i][33] ||
             pkt_done[0] !== exp_q[i][32] || (exp_q[i][34] && ch0_dat !== exp_q[i][31:0])) begin
            n_fail++;
            $display("FAIL trailer[%0d]: vld=%b eop=%b done=%b dat=%h, want vld=%b eop=%b done=%b dat=%h",
                     i, ch_vld[0], ch_eop[0], pkt_done[0], ch0_dat, exp_q[i][34], exp_q[i][33],
                     exp_q[i][32], exp_q[i][31:0]);
         end
      end
      req = 4'h0;
   endtask

   task automatic test_multichannel();
      do_reset();
      mltcn = 1'b1; ch_en = 4'hF; pkt_len = 16'd1; req = 4'hF; rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (ch_vld !== 4'hF || ch0_dat !== 32'hA500_0000 || ch1_dat !== 32'hA501_0000) begin
         n_fail++;
         $display("FAIL multi_hdr01: vld=%b ch0=%h ch1=%h, want F A5000000 A5010000",
                  ch_vld, ch0_dat, ch1_dat);
      end
      n_cmp++;
      if (ch2_dat !== 32'hA502_0000 || ch3_dat !== 32'hA503_0000) begin
         n_fail++;
         $display("FAIL multi_hdr23: ch2=%h ch3=%h, want A5020000 A5030000", ch2_dat, ch3_dat);
      end
      @(negedge clk);
      n_cmp++;
      if (ch_vld !== 4'hF || {ch0_dat, ch1_dat, ch2_dat, ch3_dat} !== 128'h0 ||
`ifdef MST_SRC_CRC_EN
          ch_eop !== 4'h0 || pkt_done !== 4'h0) begin
`else
          ch_eop !== 4'hF || pkt_done !== 4'h0) begin
`endif
         n_fail++;
         $display("FAIL multi_pay: vld=%b eop=%b done=%b dat=%h/%h/%h/%h, want payload 0 on all",
                  ch_vld, ch_eop, pkt_done, ch0_dat, ch1_dat, ch2_dat, ch3_dat);
      end
`ifdef MST_SRC_CRC_EN
      @(negedge clk);
      n_cmp++;
      if (ch_vld !== 4'hF || ch_eop !== 4'hF || {ch0_dat, ch1_dat, ch2_dat, ch3_dat} !== 128'h0) begin
         n_fail++;
         $display("FAIL multi_trl: vld=%b eop=%b, want F F with zero trailers", ch_vld, ch_eop);
      end
`endif
      @(negedge clk);
      n_cmp++;
      if (pkt_done !== 4'hF || ch_vld !== 4'h0) begin
         n_fail++;
         $display("FAIL multi_done: done=%b vld=%b, want done=1111 vld=0000", pkt_done, ch_vld);
      end
      req = 4'h0;
   endtask

   task automatic test_zero_len();
      do_reset();
      mltcn = 1'b0; ch_en = 4'b0001; pkt_len = 16'd0; req = 4'b0001; rst = 1'b0;
      exp_q.delete();
`ifdef MST_SRC_CRC_EN
      exp_q.push_back(wd(32'hA500_0000, 0)); exp_q.push_back(wd(32'h0, 1));
      exp_q.push_back(gap(1)); exp_q.push_back(gap(0));
      exp_q.push_back(wd(32'hA500_0001, 0)); exp_q.push_back(wd(32'h0, 1));
      exp_q.push_back(gap(1));
`else
      exp_q.push_back(wd(32'hA500_0000, 1)); exp_q.push_back(gap(1)); exp_q.push_back(gap(0));
      exp_q.push_back(wd(32'hA500_0001, 1)); exp_q.push_back(gap(1));
`endif
      for (int i = 0; i < exp_q.size(); i++) begin
         @(negedge clk);
         n_cmp++;
         if (ch_vld[0] !== exp_q[i][34] || ch_eop[0] !== exp_q[i][33] ||
             pkt_done[0] !== exp_q[i][32] || (exp_q[i][34] && ch0_dat !== exp_q[i][31:0])) begin
            n_fail++;
            $display("FAIL zero_len[%0d]: vld=%b eop=%b done=%b dat=%h, want vld=%b eop=%b done=%b dat=%h",
                     i, ch_vld[0], ch_eop[0], pkt_done[0], ch0_dat, exp_q[i][34], exp_q[i][33],
                     exp_q[i][32], exp_q[i][31:0]);
         end
      end
      // Header-only packets must not have advanced the payload counter
      pkt_len = 16'd1;
      exp_q.delete();
      exp_q.push_back(gap(0));
      exp_q.push_back(wd(32'hA500_0002, 0));
`ifdef MST_SRC_CRC_EN
      exp_q.push_back(wd(32'd0, 0));
      exp_q.push_back(wd(32'd0, 1));
`else
      exp_q.push_back(wd(32'd0, 1));
`endif
      exp_q.push_back(gap(1));
      for (int i = 0; i < exp_q.size(); i++) begin
         @(negedge clk);
         n_cmp++;
         if (ch_vld[0] !== exp_q[i][34] || ch_eop[0] !== exp_q[i][33] ||
             pkt_done[0] !== exp_q[i][32] || (exp_q[i][34] && ch0_dat !== exp_q[i][31:0])) begin
            n_fail++;
            $display("FAIL zero_len_pay[%0d]: vld=%b eop=%b done=%b dat=%h, want vld=%b eop=%b done=%b dat=%h",
                     i, ch_vld[0], ch_eop[0], pkt_done[0], ch0_dat, exp_q[i][34], exp_q[i][33],
                     exp_q[i][32], exp_q[i][31:0]);
         end
      end
      req = 4'h0;
   endtask

   task automatic test_req_err();
      int k;
      do_reset();
      mltcn = 1'b0; ch_en = 4'b0001; pkt_len = 16'd1; req = 4'h0; rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (req_err !== 4'h0 || ch_vld[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL err_clean: err=%b vld0=%b, want err=0000 vld0=1", req_err, ch_vld[0]);
      end
      req[0] = 1'b1;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (ch_vld[0] === 1'b1 && k < 10);
      n_cmp++;
      if (ch_vld[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL err_pkt_end: vld0=%b after %0d cycles, want 0", ch_vld[0], k);
      end
      // req stays high through this vld=0 cycle
      @(negedge clk);
      n_cmp++;
      if (req_err !== 4'b0001) begin
         n_fail++;
         $display("FAIL err_set: err=%b, want 0001", req_err);
      end
      req[0] = 1'b0;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (ch_vld[0] !== 1'b1 && k < 10);
      n_cmp++;
      if (ch_vld[0] !== 1'b1 || ch0_dat !== 32'hA500_0001) begin
         n_fail++;
         $display("FAIL err_next_hdr: vld0=%b dat=%h, want 1 A5000001", ch_vld[0], ch0_dat);
      end
      req[0] = 1'b1;
      @(negedge clk);
      req[0] = 1'b0;
      n_cmp++;
      if (ch0_dat !== 32'd1 || ch_vld[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL err_stream: vld0=%b dat=%h, want 1 00000001", ch_vld[0], ch0_dat);
      end
      repeat (4) @(negedge clk);
      n_cmp++;
      if (req_err !== 4'b0001) begin
         n_fail++;
         $display("FAIL err_sticky: err=%b, want 0001", req_err);
      end
      do_reset();
      n_cmp++;
      if (req_err !== 4'h0) begin
         n_fail++;
         $display("FAIL err_rst_clear: err=%b, want 0000", req_err);
      end
   endtask

   task automatic test_reset_mid();
      int k;
      do_reset();
      mltcn = 1'b0; ch_en = 4'b0001; pkt_len = 16'd10; req = 4'b0001; rst = 1'b0;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!(ch_vld[0] === 1'b1 && ch0_dat === 32'd5) && k < 20);
      n_cmp++;
      if (ch_vld[0] !== 1'b1 || ch0_dat !== 32'd5) begin
         n_fail++;
         $display("FAIL mid_reach5: vld0=%b dat=%h, want 1 00000005", ch_vld[0], ch0_dat);
      end
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (ch_vld !== 4'h0 || req_err !== 4'h0 || pkt_done !== 4'h0) begin
         n_fail++;
         $display("FAIL mid_rst: vld=%b err=%b done=%b, want all 0", ch_vld, req_err, pkt_done);
      end
      rst = 1'b0;
      req = 4'h0;
      @(negedge clk);
      n_cmp++;
      if (ch_vld[0] !== 1'b1 || ch0_dat !== 32'hA500_0000 || pkt_done !== 4'h0) begin
         n_fail++;
         $display("FAIL mid_hdr: vld0=%b dat=%h done=%b, want 1 A5000000 0000",
                  ch_vld[0], ch0_dat, pkt_done);
      end
      req[0] = 1'b1;
      @(negedge clk);
      req[0] = 1'b0;
      n_cmp++;
      if (ch_vld[0] !== 1'b1 || ch0_dat !== 32'd0) begin
         n_fail++;
         $display("FAIL mid_pay0: vld0=%b dat=%h, want 1 00000000", ch_vld[0], ch0_dat);
      end
   endtask

   initial begin
      rst = 1'b1; mltcn = 1'b0; ch_en = 4'h0; pkt_len = 16'd0; req = 4'h0;
      test_reset();
      test_basic();
      test_trailer();
      test_multichannel();
      test_zero_len();
      test_req_err();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
